uart_status_tx: RTL and testbench
=================================

# uart_status_tx

UART transmitter that streams a snapshot of game state (player HP, monster HP, player position, machine state) from the FPGA to the host PC on `RsTx`. It is the outbound counterpart of the keyboard receive path: the host sends keys in, and this block sends status frames out so a host-side tool can log or mirror the game. It sits in `system`, triggered by a slow tick (`clk_20hz` edge-detected into a one-cycle pulse), and drives `RsTx` directly.

## Interface

- `CLKS_PER_BIT`, default 10416 — `clk` cycles per UART bit; 100 MHz / 9600 baud, integer-truncated.
- `HEADER`, default 8'hA5 — first byte of every frame.
- `clk` in 1 — system clock, 100 MHz.
- `reset` in 1 — synchronous, active-high.
- `send` in 1 — one-cycle request to capture a snapshot and transmit one frame.
- `p_hp` in 8 — player HP.
- `mon_hp` in 8 — monster HP.
- `player_pos` in 16 — player position as {x[15:8], y[7:0]}.
- `mstate` in 8 — game machine state.
- `tx` out 1 — serial line, idle high.
- `busy` out 1 — high while a frame is in flight.
- `frame_done` out 1 — one-cycle pulse when a frame completes.

## Operation

- Frame of 7 bytes, in order: `HEADER`, `p_hp`, `mon_hp`, `player_pos[15:8]`, `player_pos[7:0]`, `mstate`, checksum.
- Checksum is the 8-bit XOR of bytes 1–5 (`p_hp` through `mstate`). The header is excluded.
- Each byte is sent 8N1: start bit 0, data LSB first, stop bit 1. Each bit holds for exactly `CLKS_PER_BIT` cycles.
- No gap between bytes: the stop bit of byte k is followed directly by the start bit of byte k+1.
- Snapshot:
  - All inputs are registered on the edge that accepts `send`.
  - Input changes during the frame do not affect it.
  - The checksum is computed from the registered copy.
- FSM states and transitions:
  - IDLE → START on accepted `send`.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits.
  - STOP → START if bytes remain; STOP → IDLE after byte 6.
- Counters:
  - Baud counter: 0..`CLKS_PER_BIT`-1, reloaded at every bit boundary.
  - Bit index: 0..7.
  - Byte index: 0..6.
- `send` is accepted only in IDLE. While busy it is ignored, not queued.
- `send` asserted in the same cycle that `frame_done` is high is accepted.
- Reset values: `tx`=1, `busy`=0, `frame_done`=0, FSM=IDLE, all counters 0.
- Reset mid-frame aborts immediately: on the next edge `tx` returns high and no partial-frame `frame_done` is issued.

## Timing

- Edge N samples `send`=1 in IDLE. From edge N: `busy`=1 and `tx`=0 (start bit of the header).
- Total frame length is 70·`CLKS_PER_BIT` cycles, measured from edge N to the edge where `busy` falls.
- At that edge `busy` falls, `frame_done` pulses for one cycle, and `tx` is 1 (IDLE).
- Bit j of the frame (j = 0..69) occupies cycles N + j·`CLKS_PER_BIT` through N + (j+1)·`CLKS_PER_BIT` − 1.
- `tx` is registered and glitch-free. It changes only at bit boundaries.

## Test plan

Bench uses `CLKS_PER_BIT`=16.

- Reset, then hold idle for 100 cycles → `tx`=1, `busy`=0, `frame_done`=0 throughout.
- Inputs `p_hp`=0x64, `mon_hp`=0x0A, `player_pos`=0x1234, `mstate`=0x03, then pulse `send` → bench UART model decodes A5 64 0A 12 34 03 4B. `busy` is high for exactly 1120 cycles, and `frame_done` pulses once at cycle 1120.
- Same frame, but change every input 50 cycles after `send` → the decoded bytes are unchanged from the previous case (snapshot holds).
- Pulse `send` again at cycles 200 and 500 mid-frame → exactly one frame is sent and only one `frame_done` is seen.
- Assert `send` on the `frame_done` cycle → the second frame's start bit begins on that edge, with 0 idle bits between the two frames.
- Assert `reset` at cycle 300 mid-frame → `tx`=1 and `busy`=0 on the next edge. No `frame_done` is seen, and a subsequent `send` produces a full, correct frame.

Source files
------------

// File: rtl/uart_status_tx.sv
// Streams a 7-byte game status frame (header, registered snapshot, XOR checksum)
// as back-to-back 8N1 characters on a registered, idle-high serial line.
module uart_status_tx #(
    parameter int         CLKS_PER_BIT = 10416,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send,
    input  logic [7:0]  p_hp,
    input  logic [7:0]  mon_hp,
    input  logic [15:0] player_pos,
    input  logic [7:0]  mstate,
    output logic        tx,
    output logic        busy,
    output logic        frame_done
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BYTE = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       byte_idx;
    logic [2:0]       data_bit_sel;
    logic             bit_done;
    logic             tx_next;
    logic             frame_done_next;

    logic [7:0] snap_p_hp;
    logic [7:0] snap_mon_hp;
    logic [7:0] snap_pos_x;
    logic [7:0] snap_pos_y;
    logic [7:0] snap_mstate;
    logic [7:0] checksum;
    logic [7:0] cur_byte;

    assign bit_done = (baud_cnt == BAUD_LAST);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (send) state_next = START;
            START:   if (bit_done) state_next = DATA;
            DATA:    if (bit_done && bit_idx == 3'd7) state_next = STOP;
            STOP:    if (bit_done) state_next = (byte_idx == LAST_BYTE) ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // The line is driven from the upcoming state so tx moves on the same edge as the FSM.
    always_comb begin
        data_bit_sel = 3'd0;
        if (state == DATA) begin
            data_bit_sel = bit_done ? bit_idx + 3'd1 : bit_idx;
        end
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = cur_byte[data_bit_sel];
            default: tx_next = 1'b1;
        endcase
        frame_done_next = (state == STOP) && bit_done && (byte_idx == LAST_BYTE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
        end else begin
            if (state == IDLE || bit_done) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    bit_idx  <= '0;
                    byte_idx <= '0;
                end
                DATA: if (bit_done) bit_idx <= bit_idx + 3'd1;
                STOP: if (bit_done) byte_idx <= (byte_idx == LAST_BYTE) ? 3'd0 : byte_idx + 3'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_p_hp   <= '0;
            snap_mon_hp <= '0;
            snap_pos_x  <= '0;
            snap_pos_y  <= '0;
            snap_mstate <= '0;
        end else if (state == IDLE && send) begin
            snap_p_hp   <= p_hp;
            snap_mon_hp <= mon_hp;
            snap_pos_x  <= player_pos[15:8];
            snap_pos_y  <= player_pos[7:0];
            snap_mstate <= mstate;
        end
    end

    assign checksum = snap_p_hp ^ snap_mon_hp ^ snap_pos_x ^ snap_pos_y ^ snap_mstate;

    always_comb begin
        case (byte_idx)
            3'd0:    cur_byte = HEADER;
            3'd1:    cur_byte = snap_p_hp;
            3'd2:    cur_byte = snap_mon_hp;
            3'd3:    cur_byte = snap_pos_x;
            3'd4:    cur_byte = snap_pos_y;
            3'd5:    cur_byte = snap_mstate;
            3'd6:    cur_byte = checksum;
            default: cur_byte = HEADER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            tx         <= tx_next;
            frame_done <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_uart_status_tx.sv
// Directed bench for uart_status_tx: logs the line cycle by cycle and decodes
// it with a mid-bit sampling UART model against hand-computed frames.
module tb_uart_status_tx;

    localparam int CPB          = 16;
    localparam int FRAME_CYCLES = 70 * CPB;
    localparam int WIN          = 2 * FRAME_CYCLES + 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        send;
    logic [7:0]  p_hp;
    logic [7:0]  mon_hp;
    logic [15:0] player_pos;
    logic [7:0]  mstate;
    logic        tx;
    logic        busy;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    logic       tx_log   [WIN];
    logic       busy_log [WIN];
    logic       done_log [WIN];
    logic [7:0] exp_main [7];

    uart_status_tx #(
        .CLKS_PER_BIT(CPB),
        .HEADER      (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .send      (send),
        .p_hp      (p_hp),
        .mon_hp    (mon_hp),
        .player_pos(player_pos),
        .mstate    (mstate),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] hp, input logic [7:0] mhp,
                                 input logic [15:0] pos, input logic [7:0] ms);
        p_hp       = hp;
        mon_hp     = mhp;
        player_pos = pos;
        mstate     = ms;
    endtask

    // Index i of the logs is the cycle i after the edge that accepted send.
    task automatic capture(input int mode, input int len);
        @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        for (int i = 0; i < len; i++) begin
            tx_log[i]   = tx;
            busy_log[i] = busy;
            done_log[i] = frame_done;
            case (mode)
                1: if (i == 50) applyStimulus(8'hFF, 8'hEE, 16'hDDCC, 8'hBB);
                2: send = (i == 200 || i == 500);
                3: reset = (i == 300);
                4: send = (i == FRAME_CYCLES) && (frame_done === 1'b1);
                default: ;
            endcase
            @(negedge clk);
        end
        send  = 1'b0;
        reset = 1'b0;
    endtask

    task automatic check_timing(input string tag, input int base);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        for (int i = base; i <= base + FRAME_CYCLES; i++) begin
            if (busy_log[i] === 1'b1) busy_cnt++;
            if (done_log[i] === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i - base;
            end
        end
        checkOutput({tag, " start bit"}, 32'(tx_log[base]), 32'd0);
        checkOutput({tag, " busy cycles"}, busy_cnt, FRAME_CYCLES);
        checkOutput({tag, " done count"}, done_cnt, 1);
        checkOutput({tag, " done cycle"}, done_at, FRAME_CYCLES);
        checkOutput({tag, " idle after"}, 32'(tx_log[base + FRAME_CYCLES]), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int base);
        int         ferr = 0;
        logic [7:0] d;
        logic       s;
        for (int k = 0; k < 7; k++) begin
            d = 8'h00;
            for (int b = 0; b < 10; b++) begin
                s = tx_log[base + (10 * k + b) * CPB + CPB / 2];
                if (b == 0) begin
                    if (s !== 1'b0) ferr++;
                end else if (b == 9) begin
                    if (s !== 1'b1) ferr++;
                end else begin
                    d[b-1] = s;
                end
            end
            checkOutput($sformatf("%s byte%0d", tag, k), 32'(d), 32'(exp_main[k]));
        end
        checkOutput({tag, " framing"}, ferr, 0);
    endtask

    initial begin
        int idle_err;
        int done_cnt;

        exp_main[0] = 8'hA5;
        exp_main[1] = 8'h64;
        exp_main[2] = 8'h0A;
        exp_main[3] = 8'h12;
        exp_main[4] = 8'h34;
        exp_main[5] = 8'h03;
        exp_main[6] = 8'h4B;

        reset = 1'b1;
        send  = 1'b0;
        applyStimulus(8'h64, 8'h0A, 16'h1234, 8'h03);
        repeat (3) @(negedge clk);
        checkOutput("reset tx", 32'(tx), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset frame_done", 32'(frame_done), 32'd0);
        reset = 1'b0;

        idle_err = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) idle_err++;
        end
        checkOutput("idle hold", idle_err, 0);

        $display("[TB] basic frame");
        capture(0, FRAME_CYCLES + 10);
        check_timing("basic", 0);
        check_frame("basic", 0);

        $display("[TB] snapshot hold");
        capture(1, FRAME_CYCLES + 10);
        check_timing("snapshot", 0);
        check_frame("snapshot", 0);
        applyStimulus(8'h64, 8'h0A, 16'h1234, 8'h03);

        $display("[TB] send ignored while busy");
        capture(2, FRAME_CYCLES + 10);
        check_timing("ignore", 0);
        check_frame("ignore", 0);
        done_cnt = 0;
        for (int i = 0; i < FRAME_CYCLES + 10; i++) if (done_log[i] === 1'b1) done_cnt++;
        checkOutput("ignore total done", done_cnt, 1);

        $display("[TB] back-to-back frames");
        capture(4, WIN);
        check_timing("b2b first", 0);
        check_frame("b2b first", 0);
        checkOutput("b2b busy restart", 32'(busy_log[FRAME_CYCLES + 1]), 32'd1);
        check_timing("b2b second", FRAME_CYCLES + 1);
        check_frame("b2b second", FRAME_CYCLES + 1);

        $display("[TB] reset mid-frame");
        capture(3, 400);
        checkOutput("abort busy before", 32'(busy_log[300]), 32'd1);
        checkOutput("abort tx", 32'(tx_log[301]), 32'd1);
        checkOutput("abort busy", 32'(busy_log[301]), 32'd0);
        done_cnt = 0;
        idle_err = 0;
        for (int i = 0; i < 400; i++) begin
            if (done_log[i] === 1'b1) done_cnt++;
            if (i > 301 && (tx_log[i] !== 1'b1 || busy_log[i] !== 1'b0)) idle_err++;
        end
        checkOutput("abort no done", done_cnt, 0);
        checkOutput("abort stays idle", idle_err, 0);
        repeat (5) @(negedge clk);
        capture(0, FRAME_CYCLES + 10);
        check_timing("after abort", 0);
        check_frame("after abort", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
